conv_seq_ctrl: RTL and testbench
================================

Name: conv_seq_ctrl

Overview:
Parametrised sequencer for the convolution accelerator datapath. It loads a TAPS-word kernel from the input SRAM at a configurable base, then streams a configurable-length ifmap to the conv engine. Conv results are counted into output-SRAM write addresses. Results are also packed into BN batches with a fixed-latency BN handshake and a one-entry pending buffer. It sits between the ICB-configured registers and the conv/BN datapath.

Parameters:
DATA_W, 32, SRAM word width; must be a multiple of 16
ADDR_W, 13, SRAM address width
TAPS, 9, kernel words loaded per run
BN_GROUP, 4, 16-bit conv results per BN batch
BN_LAT, 12, cycles from bn_start to bn_valid

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
start  in  1  run request; sampled in IDLE only
cfg_wbase  in  ADDR_W  kernel base address
cfg_ifmap_len  in  ADDR_W  ifmap words to stream
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse at end of run
rd_en  out  1  input SRAM read enable
rd_addr  out  ADDR_W  input SRAM read address
rd_data  in  DATA_W  read data, valid the cycle after rd_en
kernel  out  TAPS*DATA_W  kernel regs; word i = SRAM[cfg_wbase+i]
conv_data  out  DATA_W  ifmap word to the conv engine
conv_valid  out  1  conv_data qualifier
conv_out  in  DATA_W  conv result; bits [15:0] are used for BN
conv_out_valid  in  1  conv result qualifier
wr_en  out  1  output SRAM write enable; equals conv_out_valid
wr_addr  out  ADDR_W  output SRAM write address
bn_data  out  BN_GROUP*16  BN batch; element 0 is the oldest result
bn_start  out  1  one-cycle BN launch
bn_valid  out  1  one-cycle pulse BN_LAT cycles after bn_start
bn_ovf  out  1  sticky overflow flag

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: all outputs 0, kernel 0, state IDLE, all counters 0. Reset mid-run aborts immediately with no done pulse.
- FSM states: IDLE, WLOAD, STREAM, DRAIN.
- IDLE:
  - start=1 latches cfg_wbase and cfg_ifmap_len, clears wr_addr and bn_ovf, and moves to WLOAD.
  - start while busy is ignored.
- WLOAD:
  - Issues TAPS consecutive reads (rd_en=1), addresses cfg_wbase to cfg_wbase+TAPS-1, one per cycle. Address arithmetic wraps modulo 2^ADDR_W.
  - Each returned word is written to kernel[i] the cycle after its read.
  - Once the last kernel word is captured: go to STREAM, or to DRAIN if len==0.
  - A run with len==0 therefore lasts TAPS+1 cycles, then done.
- STREAM:
  - Issues len reads at addresses 0 to len-1.
  - conv_data<=rd_data and conv_valid=1 on the cycle after each read. There are no bubbles between words.
- DRAIN:
  - Lasts one cycle: it holds the final conv_valid, then pulses done and returns to IDLE.
  - Run latency from start to done = TAPS + len + 2 cycles.
- wr_addr:
  - Increments by 1 per conv_out_valid, in any state, and wraps.
  - wr_addr always presents the current address, i.e. the one used for this write.
- BN packer:
  - Each conv_out_valid shifts conv_out[15:0] into the pack register.
  - The BN_GROUP-th entry completes a batch.
  - If the BN engine is idle, bn_data<=batch and bn_start is pulsed the next cycle.
  - If the BN engine is busy, the batch goes into the pending slot.
  - The BN timer counts BN_LAT cycles, then pulses bn_valid.
  - In the bn_valid cycle, a held pending batch is launched in the same cycle (bn_start=1). This gives back-to-back batches with no gap.
  - If a batch completes while pending is already full: the new batch is dropped, bn_ovf=1 (sticky), and the pack count restarts.
  - The packer is not cleared by done. Partial batches carry over into the next run.

Optional Feature:
ACC_WEIGHT_REUSE_EN
- Enabled:
  - Adds input port reuse_w (1 bit) and an internal kernel_loaded flag.
  - kernel_loaded is set after a completed WLOAD and cleared by reset.
  - start with reuse_w=1 and kernel_loaded=1 skips WLOAD and goes straight to STREAM. Latency becomes len + 2 cycles.
- Disabled:
  - The reuse_w port is absent and every run loads the kernel.

Decomposition:
- Package acc_pkg holds:
  - the state enum (IDLE, WLOAD, STREAM, DRAIN);
  - the constant BN_ELEM_W=16;
  - the ADDR_W/DATA_W defaults shared with the SRAM models.
- Sub-module bn_packer contains the pack register, pack count, pending slot, BN timer, bn_start/bn_valid and bn_ovf.
- The top level contains the FSM, read addressing, kernel capture and wr_addr.

Test Plan:
- Kernel load: SRAM[7680+i]=i+1, wbase=7680, len=4, start → kernel[i]=i+1, conv_data 4 consecutive words from addresses 0..3, done at cycle 15 after start.
- Zero length: len=0 → no conv_valid, done 10 cycles after start, busy low the following cycle.
- BN back-to-back: 8 consecutive conv_out_valid with values 1..8 → bn_start with {4,3,2,1}; second batch pends; bn_valid at +12 coincides with bn_start carrying {8,7,6,5}; bn_ovf=0.
- BN overflow: 12 consecutive conv_out_valid → third batch dropped, bn_ovf=1 until next start.
- Wrap and ignored start: wbase=8190 → reads at 8190, 8191, 0..6. start pulsed mid-STREAM → no effect. rst_n low mid-WLOAD → all outputs 0, no done.
- Reuse (ACC_WEIGHT_REUSE_EN): second run with reuse_w=1 → no reads in the 7680 range, done after len+2 cycles.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared types and constants for the convolution accelerator sequencer.
package acc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WLOAD,
    STREAM,
    DRAIN
  } state_t;

  localparam int BN_ELEM_W  = 16;
  localparam int DEF_ADDR_W = 13;
  localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/bn_packer.sv
// Packs 16-bit conv results into BN batches; fixed-latency BN handshake
// with a one-entry pending slot and a sticky overflow flag.
module bn_packer
  import acc_pkg::*;
#(
  parameter int BN_GROUP = 4,
  parameter int BN_LAT   = 12
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic [BN_ELEM_W-1:0]          in_data,
  input  logic                          in_valid,
  output logic [BN_GROUP*BN_ELEM_W-1:0] bn_data,
  output logic                          bn_start,
  output logic                          bn_valid,
  output logic                          bn_ovf
);

  localparam int PW = BN_GROUP * BN_ELEM_W;
  localparam int CW = $clog2(BN_GROUP + 1);
  localparam int TW = $clog2(BN_LAT + 1);

  logic [PW-BN_ELEM_W-1:0] hist;
  logic [PW-1:0]           batch;
  logic [PW-1:0]           pend;
  logic                    pend_v;
  logic                    eng_busy;
  logic [CW-1:0]           cnt;
  logic [TW-1:0]           timer;
  logic                    complete;
  logic                    eng_done;
  logic                    free;

  always_comb begin
    batch    = {in_data, hist};
    complete = in_valid && (cnt == CW'(BN_GROUP - 1));
    eng_done = eng_busy && (timer == '0);
    // An engine finishing this cycle with nothing pending can take a new batch directly.
    free     = !eng_busy || (eng_done && !pend_v);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist     <= '0;
      pend     <= '0;
      pend_v   <= 1'b0;
      eng_busy <= 1'b0;
      cnt      <= '0;
      timer    <= '0;
      bn_data  <= '0;
      bn_start <= 1'b0;
      bn_valid <= 1'b0;
      bn_ovf   <= 1'b0;
    end else begin
      bn_start <= 1'b0;
      bn_valid <= 1'b0;
      if (in_valid) begin
        hist <= batch[PW-1:BN_ELEM_W];
        cnt  <= complete ? '0 : cnt + CW'(1);
      end
      if (eng_busy) timer <= timer - TW'(1);
      if (eng_done) begin
        bn_valid <= 1'b1;
        if (pend_v) begin
          bn_data  <= pend;
          bn_start <= 1'b1;
          timer    <= TW'(BN_LAT - 1);
          pend_v   <= 1'b0;
        end else begin
          eng_busy <= 1'b0;
        end
      end
      if (clr) bn_ovf <= 1'b0;
      if (complete) begin
        if (free) begin
          bn_data  <= batch;
          bn_start <= 1'b1;
          eng_busy <= 1'b1;
          timer    <= TW'(BN_LAT - 1);
        end else if (!pend_v || eng_done) begin
          pend   <= batch;
          pend_v <= 1'b1;
        end else begin
          bn_ovf <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/conv_seq_ctrl.sv
// Conv datapath sequencer: kernel load, ifmap streaming, output addressing, BN packing.
// Optional build macro ACC_WEIGHT_REUSE_EN adds reuse_w to skip reloading a loaded kernel.
module conv_seq_ctrl
  import acc_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int TAPS     = 9,
  parameter int BN_GROUP = 4,
  parameter int BN_LAT   = 12
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
`ifdef ACC_WEIGHT_REUSE_EN
  input  logic                          reuse_w,
`endif
  input  logic [ADDR_W-1:0]             cfg_wbase,
  input  logic [ADDR_W-1:0]             cfg_ifmap_len,
  output logic                          busy,
  output logic                          done,
  output logic                          rd_en,
  output logic [ADDR_W-1:0]             rd_addr,
  input  logic [DATA_W-1:0]             rd_data,
  output logic [TAPS*DATA_W-1:0]        kernel,
  output logic [DATA_W-1:0]             conv_data,
  output logic                          conv_valid,
  input  logic [DATA_W-1:0]             conv_out,
  input  logic                          conv_out_valid,
  output logic                          wr_en,
  output logic [ADDR_W-1:0]             wr_addr,
  output logic [BN_GROUP*BN_ELEM_W-1:0] bn_data,
  output logic                          bn_start,
  output logic                          bn_valid,
  output logic                          bn_ovf
);

  state_t            state;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] ld_idx;
  logic              ld_v;
  logic              cv_pend;
  logic              accept;
  logic              do_reuse;
  logic              unused_conv_hi;

`ifdef ACC_WEIGHT_REUSE_EN
  logic kernel_loaded;
  assign do_reuse = reuse_w && kernel_loaded;
`else
  assign do_reuse = 1'b0;
`endif

  assign accept         = start && (state == IDLE);
  assign busy           = (state != IDLE);
  assign wr_en          = conv_out_valid;
  assign unused_conv_hi = ^conv_out[DATA_W-1:BN_ELEM_W];

  // Stream reads start right behind the last kernel read; STREAM keeps one
  // trailing cycle so DRAIN lines up with the final conv_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      done    <= 1'b0;
      len_q   <= '0;
      cnt     <= '0;
`ifdef ACC_WEIGHT_REUSE_EN
      kernel_loaded <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            len_q <= cfg_ifmap_len;
            cnt   <= '0;
            if (do_reuse) begin
              if (cfg_ifmap_len == '0) begin
                state <= DRAIN;
                done  <= 1'b1;
              end else begin
                state   <= STREAM;
                rd_en   <= 1'b1;
                rd_addr <= '0;
              end
            end else begin
              state   <= WLOAD;
              rd_en   <= 1'b1;
              rd_addr <= cfg_wbase;
            end
          end
        end
        WLOAD: begin
          if (cnt == ADDR_W'(TAPS - 1)) begin
            cnt <= '0;
`ifdef ACC_WEIGHT_REUSE_EN
            kernel_loaded <= 1'b1;
`endif
            if (len_q == '0) begin
              state <= DRAIN;
              rd_en <= 1'b0;
              done  <= 1'b1;
            end else begin
              state   <= STREAM;
              rd_addr <= '0;
            end
          end else begin
            cnt     <= cnt + ADDR_W'(1);
            rd_addr <= rd_addr + ADDR_W'(1);
          end
        end
        STREAM: begin
          if (rd_en) begin
            if (cnt == len_q - ADDR_W'(1)) begin
              rd_en <= 1'b0;
            end else begin
              cnt     <= cnt + ADDR_W'(1);
              rd_addr <= rd_addr + ADDR_W'(1);
            end
          end else begin
            state <= DRAIN;
            done  <= 1'b1;
          end
        end
        DRAIN:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_v       <= 1'b0;
      ld_idx     <= '0;
      cv_pend    <= 1'b0;
      kernel     <= '0;
      conv_data  <= '0;
      conv_valid <= 1'b0;
      wr_addr    <= '0;
    end else begin
      ld_v       <= rd_en && (state == WLOAD);
      ld_idx     <= cnt;
      cv_pend    <= rd_en && (state == STREAM);
      conv_valid <= cv_pend;
      if (cv_pend) conv_data <= rd_data;
      for (int unsigned i = 0; i < TAPS; i++) begin
        if (ld_v && (ld_idx == ADDR_W'(i))) kernel[i*DATA_W +: DATA_W] <= rd_data;
      end
      if (accept)              wr_addr <= '0;
      else if (conv_out_valid) wr_addr <= wr_addr + ADDR_W'(1);
    end
  end

  bn_packer #(
    .BN_GROUP (BN_GROUP),
    .BN_LAT   (BN_LAT)
  ) u_bn_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (accept),
    .in_data  (conv_out[BN_ELEM_W-1:0]),
    .in_valid (conv_out_valid),
    .bn_data  (bn_data),
    .bn_start (bn_start),
    .bn_valid (bn_valid),
    .bn_ovf   (bn_ovf)
  );

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed self-checking bench for conv_seq_ctrl (default parameters).
module tb_conv_seq_ctrl;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          reuse_w;
  logic [12:0]   cfg_wbase;
  logic [12:0]   cfg_ifmap_len;
  logic          busy, done, rd_en;
  logic [12:0]   rd_addr;
  logic [31:0]   rd_data;
  logic [287:0]  kernel;
  logic [31:0]   conv_data;
  logic          conv_valid;
  logic [31:0]   conv_out;
  logic          conv_out_valid;
  logic          wr_en;
  logic [12:0]   wr_addr;
  logic [63:0]   bn_data;
  logic          bn_start, bn_valid, bn_ovf;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [8192];
  int          rd_q [$];
  logic [31:0] cv_q [$];
  int          done_cyc;
  int          bs_q [$];
  int          bv_q [$];
  logic [63:0] bd_q [$];
  logic        ovf_at [64];

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  conv_seq_ctrl #(
    .DATA_W   (32),
    .ADDR_W   (13),
    .TAPS     (9),
    .BN_GROUP (4),
    .BN_LAT   (12)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
`ifdef ACC_WEIGHT_REUSE_EN
    .reuse_w        (reuse_w),
`endif
    .cfg_wbase      (cfg_wbase),
    .cfg_ifmap_len  (cfg_ifmap_len),
    .busy           (busy),
    .done           (done),
    .rd_en          (rd_en),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .kernel         (kernel),
    .conv_data      (conv_data),
    .conv_valid     (conv_valid),
    .conv_out       (conv_out),
    .conv_out_valid (conv_out_valid),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .bn_data        (bn_data),
    .bn_start       (bn_start),
    .bn_valid       (bn_valid),
    .bn_ovf         (bn_ovf)
  );

  function automatic logic [31:0] memval(input int a);
    if (a >= 7680 && a < 7689) return 32'(a - 7680 + 1);
    return 32'hA000_0000 + 32'(a);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Call at a negedge; cycle n is observed at the n-th following negedge.
  task automatic run_seq(input int wb, input int ln, input logic ru, input int pulse_at, input int limit);
    rd_q.delete();
    cv_q.delete();
    done_cyc      = -1;
    cfg_wbase     = 13'(wb);
    cfg_ifmap_len = 13'(ln);
`ifdef ACC_WEIGHT_REUSE_EN
    reuse_w = ru;
`else
    reuse_w = 1'b0;
    if (ru) $display("note: reuse requested but not built in");
`endif
    start = 1'b1;
    for (int n = 1; n <= limit; n++) begin
      @(negedge clk);
      start = (n == pulse_at);
      if (rd_en) rd_q.push_back(int'(rd_addr));
      if (conv_valid) cv_q.push_back(conv_data);
      if (done) begin
        done_cyc = n;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic chk_reads(input string tag, input int wb, input int nk, input int ns);
    check({tag, "_nreads"}, rd_q.size(), nk + ns);
    for (int i = 0; i < nk + ns; i++) begin
      if (i < rd_q.size())
        check({tag, "_rd_addr"}, rd_q[i], (i < nk) ? ((wb + i) % 8192) : (i - nk));
    end
  endtask

  task automatic chk_conv(input string tag, input int n);
    check({tag, "_nconv"}, cv_q.size(), n);
    for (int j = 0; j < n; j++) begin
      if (j < cv_q.size()) check({tag, "_conv_data"}, cv_q[j], memval(j));
    end
  endtask

  task automatic bn_burst(input int nv, input logic [15:0] base, input int ncyc);
    bs_q.delete();
    bv_q.delete();
    bd_q.delete();
    for (int n = 0; n < ncyc; n++) begin
      conv_out_valid = (n < nv);
      conv_out       = {16'hDEAD, base + 16'(n)};
      @(negedge clk);
      if (bn_start) begin
        bs_q.push_back(n + 1);
        bd_q.push_back(bn_data);
      end
      if (bn_valid) bv_q.push_back(n + 1);
      if (n + 1 < 64) ovf_at[n + 1] = bn_ovf;
    end
    conv_out_valid = 1'b0;
  endtask

  initial begin
    int ndone;
    rst_n          = 1'b0;
    start          = 1'b0;
    reuse_w        = 1'b0;
    cfg_wbase      = '0;
    cfg_ifmap_len  = '0;
    conv_out       = '0;
    conv_out_valid = 1'b0;
    for (int a = 0; a < 8192; a++) mem[a] = memval(a);

    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_kernel", |kernel, 0);
    check("rst_conv", {conv_valid, conv_data}, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_bn", {bn_start, bn_valid, bn_ovf, bn_data}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Kernel load then 4-word stream
    run_seq(7680, 4, 1'b0, 0, 40);
    check("t1_done_cyc", done_cyc, 15);
    chk_reads("t1", 7680, 9, 4);
    chk_conv("t1", 4);
    for (int i = 0; i < 9; i++) check("t1_kernel", kernel[i*32 +: 32], 32'(i + 1));
    @(negedge clk);
    check("t1_busy_after", busy, 0);
    check("t1_done_pulse", done, 0);

    // Zero-length run
    run_seq(7680, 0, 1'b0, 0, 40);
    check("t2_done_cyc", done_cyc, 10);
    check("t2_nconv", cv_q.size(), 0);
    chk_reads("t2", 7680, 9, 0);
    @(negedge clk);
    check("t2_busy_after", busy, 0);

    // BN back-to-back: values 1..8
    conv_out_valid = 1'b1;
    conv_out       = 32'h0000_0001;
    #1;
    check("t3_wr_en", wr_en, 1);
    check("t3_wr_addr0", wr_addr, 0);
    @(negedge clk);
    conv_out_valid = 1'b0;
    // restart the burst from a clean pack count: undo the single entry by
    // folding it into the burst as value 1
    bs_q.delete();
    bn_burst_from_second();
    check("t3_nstart", bs_q.size(), 2);
    if (bs_q.size() == 2) begin
      check("t3_start0_cyc", bs_q[0], 4);
      check("t3_start0_data", bd_q[0], 64'h0004_0003_0002_0001);
      check("t3_start1_cyc", bs_q[1], 16);
      check("t3_start1_data", bd_q[1], 64'h0008_0007_0006_0005);
    end
    check("t3_nvalid", bv_q.size(), 2);
    if (bv_q.size() == 2) begin
      check("t3_valid0_cyc", bv_q[0], 16);
      check("t3_valid1_cyc", bv_q[1], 28);
    end
    check("t3_ovf", bn_ovf, 0);
    check("t3_wr_addr", wr_addr, 8);

    // BN overflow: 12 results, third batch dropped
    bn_burst(12, 16'h0010, 34);
    check("t4_nstart", bs_q.size(), 2);
    if (bs_q.size() == 2) begin
      check("t4_start0_data", bd_q[0], 64'h0013_0012_0011_0010);
      check("t4_start1_data", bd_q[1], 64'h0017_0016_0015_0014);
    end
    check("t4_ovf_before", ovf_at[11], 0);
    check("t4_ovf_set", ovf_at[12], 1);
    check("t4_ovf_sticky", bn_ovf, 1);
    check("t4_wr_addr", wr_addr, 20);

    // Wrapped kernel base, start pulsed mid-STREAM
    run_seq(8190, 2, 1'b0, 11, 40);
    check("t5_done_cyc", done_cyc, 13);
    chk_reads("t5", 8190, 9, 2);
    chk_conv("t5", 2);
    check("t5_kernel0", kernel[0 +: 32], memval(8190));
    check("t5_kernel1", kernel[32 +: 32], memval(8191));
    check("t5_kernel8", kernel[8*32 +: 32], memval(6));
    check("t5_ovf_cleared", bn_ovf, 0);
    check("t5_wr_addr_cleared", wr_addr, 0);
    @(negedge clk);
    check("t5_idle", busy, 0);

    // Reset in the middle of WLOAD
    cfg_wbase     = 13'd7680;
    cfg_ifmap_len = 13'd4;
    start         = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("t6_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_ctrl", {busy, done, rd_en, rd_addr}, 0);
    check("t6_rst_kernel", |kernel, 0);
    check("t6_rst_conv", {conv_valid, conv_data}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("t6_no_done", ndone, 0);

`ifdef ACC_WEIGHT_REUSE_EN
    // reuse_w without a loaded kernel still loads
    run_seq(7680, 3, 1'b1, 0, 40);
    check("t7_first_done_cyc", done_cyc, 14);
    chk_reads("t7a", 7680, 9, 3);
    @(negedge clk);
    run_seq(7680, 3, 1'b1, 0, 40);
    check("t7_reuse_done_cyc", done_cyc, 5);
    chk_reads("t7b", 0, 0, 3);
    chk_conv("t7b", 3);
    check("t7_kernel_kept", kernel[4*32 +: 32], 32'd5);
    @(negedge clk);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Continues the 1..8 burst after the first result was driven inline.
  task automatic bn_burst_from_second();
    bs_q.delete();
    bv_q.delete();
    bd_q.delete();
    for (int n = 1; n < 32; n++) begin
      conv_out_valid = (n < 8);
      conv_out       = {16'hBEEF, 16'(n + 1)};
      @(negedge clk);
      if (bn_start) begin
        bs_q.push_back(n + 1);
        bd_q.push_back(bn_data);
      end
      if (bn_valid) bv_q.push_back(n + 1);
    end
    conv_out_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
